// File: rtl/ldq_cam_ctrl.sv
// ldq_cam_ctrl -- load-queue address CAM controller and search-port scheduler.
//
// After reset the controller sweeps the CAM, writing zero to two entries per
// cycle. It then forwards two-lane load-address writes to the CAM.
// The two CAM tag-search ports are shared among NUM_REQ requesters through a
// round-robin scan. Each granted search returns a registered match vector,
// masked by the occupied-entry mask, one cycle after the grant.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   ready_o               init sweep finished; writes and searches accepted
//   reqValid_i/reqTag_i   per-requester search request and tag
//   reqReady_o            per-requester grant (combinational)
//   rspValid_o/rspVect_o  per-requester registered result
//   entryValid_i          occupied-entry mask applied to every result
//   wrValid_i/wrAddr_i/wrData_i, wrReady_o   two-lane address write
//   camTag*_o, camVect*_i                    CAM search ports
//   camWe*_o, camWrAddr*_o, camWrData*_o     CAM write ports
//
// Optional build macro: LDQ_WR_BYPASS_EN
//   When defined, each result is corrected for writes in the same cycle, so a
//   search sees the post-write contents. Lane 0 is applied first and lane 1
//   second, so lane 1 wins. When undefined, same-cycle writes are invisible to
//   the search.

module ldq_cam_ctrl #(
  parameter int DEPTH   = 16,
  parameter int INDEX   = 4,
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     ready_o,
  input  logic [NUM_REQ-1:0]       reqValid_i,
  input  logic [NUM_REQ*WIDTH-1:0] reqTag_i,
  output logic [NUM_REQ-1:0]       reqReady_o,
  output logic [NUM_REQ-1:0]       rspValid_o,
  output logic [NUM_REQ*DEPTH-1:0] rspVect_o,
  input  logic [DEPTH-1:0]         entryValid_i,
  input  logic [1:0]               wrValid_i,
  input  logic [2*INDEX-1:0]       wrAddr_i,
  input  logic [2*WIDTH-1:0]       wrData_i,
  output logic                     wrReady_o,
  output logic [WIDTH-1:0]         camTag0_o,
  output logic [WIDTH-1:0]         camTag1_o,
  input  logic [DEPTH-1:0]         camVect0_i,
  input  logic [DEPTH-1:0]         camVect1_i,
  output logic                     camWe0_o,
  output logic                     camWe1_o,
  output logic [INDEX-1:0]         camWrAddr0_o,
  output logic [INDEX-1:0]         camWrAddr1_o,
  output logic [WIDTH-1:0]         camWrData0_o,
  output logic [WIDTH-1:0]         camWrData1_o
);

  localparam int RR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic [INDEX-1:0] init_ptr;
  logic [RR_W-1:0]  rr_ptr;
  logic             init_last;

  logic [INDEX-1:0] wr_addr0;
  logic [INDEX-1:0] wr_addr1;
  logic [WIDTH-1:0] wr_data0;
  logic [WIDTH-1:0] wr_data1;
  logic [1:0]       wr_lane;

  logic [WIDTH-1:0] req_tag [NUM_REQ];

  logic [RR_W:0]        scan_sum;
  logic [RR_W-1:0]      scan_idx;
  logic [NUM_REQ-1:0]   grant_p0;
  logic                 port0_vld_p0;
  logic                 port1_vld_p0;
  logic [RR_W-1:0]      port0_idx_p0;
  logic [RR_W-1:0]      port1_idx_p0;
  logic [RR_W-1:0]      last_idx_p0;
  logic [RR_W-1:0]      rr_next_p0;
  logic [DEPTH-1:0]     port0_vect_p0;
  logic [DEPTH-1:0]     port1_vect_p0;

`ifdef LDQ_WR_BYPASS_EN
  // Overlay same-cycle writes onto a match vector: lane 0 first, lane 1 last.
  function automatic logic [DEPTH-1:0] wr_bypass(
    input logic [DEPTH-1:0] vect,
    input logic [WIDTH-1:0] tag,
    input logic [1:0]       lane,
    input logic [INDEX-1:0] addr0,
    input logic [INDEX-1:0] addr1,
    input logic [WIDTH-1:0] data0,
    input logic [WIDTH-1:0] data1,
    input logic [DEPTH-1:0] valid
  );
    logic [DEPTH-1:0] res;
    res = vect;
    if (lane[0]) res[addr0] = (data0 == tag) & valid[addr0];
    if (lane[1]) res[addr1] = (data1 == tag) & valid[addr1];
    return res;
  endfunction
`endif

  assign init_last = (init_ptr == INDEX'(DEPTH - 2));

  assign wr_addr0 = wrAddr_i[INDEX-1:0];
  assign wr_addr1 = wrAddr_i[2*INDEX-1:INDEX];
  assign wr_data0 = wrData_i[WIDTH-1:0];
  assign wr_data1 = wrData_i[2*WIDTH-1:WIDTH];

  // Everything outside the init sweep is held off until ready_o, which lags
  // the INIT->RUN transition by one edge.
  assign wr_lane   = wrValid_i & {2{ready_o}};
  assign wrReady_o = ready_o;

  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      req_tag[r] = reqTag_i[r*WIDTH +: WIDTH];
    end
  end

  // ---- stage p0: FSM, init sweep, write forwarding ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_INIT;
      init_ptr <= '0;
      ready_o  <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      ready_o <= (state == ST_RUN);
      if (state == ST_INIT) begin
        init_ptr <= init_ptr + INDEX'(2);
        if (init_last) begin
          state    <= ST_RUN;
          init_ptr <= '0;
        end
      end
      if (|grant_p0) rr_ptr <= rr_next_p0;
    end
  end

  always_comb begin
    camWe0_o     = 1'b0;
    camWe1_o     = 1'b0;
    camWrAddr0_o = '0;
    camWrAddr1_o = '0;
    camWrData0_o = '0;
    camWrData1_o = '0;
    if (state == ST_INIT) begin
      camWe0_o     = 1'b1;
      camWe1_o     = 1'b1;
      camWrAddr0_o = init_ptr;
      camWrAddr1_o = init_ptr + INDEX'(1);
    end else begin
      // Same-address collision: drop lane 0 so lane 1's data lands.
      camWe0_o     = wr_lane[0] & ~(wr_lane[1] & (wr_addr0 == wr_addr1));
      camWe1_o     = wr_lane[1];
      camWrAddr0_o = wr_addr0;
      camWrAddr1_o = wr_addr1;
      camWrData0_o = wr_data0;
      camWrData1_o = wr_data1;
    end
  end

  // Round-robin scan starting at rr_ptr: first valid -> port 0, second -> port 1.
  always_comb begin
    scan_sum     = '0;
    scan_idx     = '0;
    grant_p0     = '0;
    port0_vld_p0 = 1'b0;
    port1_vld_p0 = 1'b0;
    port0_idx_p0 = '0;
    port1_idx_p0 = '0;
    last_idx_p0  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_sum = {1'b0, rr_ptr} + (RR_W+1)'(i);
      if (scan_sum >= (RR_W+1)'(NUM_REQ)) scan_sum = scan_sum - (RR_W+1)'(NUM_REQ);
      scan_idx = scan_sum[RR_W-1:0];
      if (ready_o && reqValid_i[scan_idx]) begin
        if (!port0_vld_p0) begin
          port0_vld_p0       = 1'b1;
          port0_idx_p0       = scan_idx;
          grant_p0[scan_idx] = 1'b1;
          last_idx_p0        = scan_idx;
        end else if (!port1_vld_p0) begin
          port1_vld_p0       = 1'b1;
          port1_idx_p0       = scan_idx;
          grant_p0[scan_idx] = 1'b1;
          last_idx_p0        = scan_idx;
        end
      end
    end
    rr_next_p0 = (last_idx_p0 == RR_W'(NUM_REQ - 1)) ? '0 : last_idx_p0 + RR_W'(1);
  end

  assign reqReady_o = grant_p0;
  assign camTag0_o  = port0_vld_p0 ? req_tag[port0_idx_p0] : '0;
  assign camTag1_o  = port1_vld_p0 ? req_tag[port1_idx_p0] : '0;

`ifdef LDQ_WR_BYPASS_EN
  assign port0_vect_p0 = wr_bypass(camVect0_i & entryValid_i, camTag0_o, wr_lane,
                                   wr_addr0, wr_addr1, wr_data0, wr_data1, entryValid_i);
  assign port1_vect_p0 = wr_bypass(camVect1_i & entryValid_i, camTag1_o, wr_lane,
                                   wr_addr0, wr_addr1, wr_data0, wr_data1, entryValid_i);
`else
  assign port0_vect_p0 = camVect0_i & entryValid_i;
  assign port1_vect_p0 = camVect1_i & entryValid_i;
`endif

  // ---- stage p1: registered responses; non-granted vectors hold ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rspValid_o <= '0;
      rspVect_o  <= '0;
    end else begin
      rspValid_o <= grant_p0;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (port0_vld_p0 && (port0_idx_p0 == RR_W'(r))) begin
          rspVect_o[r*DEPTH +: DEPTH] <= port0_vect_p0;
        end else if (port1_vld_p0 && (port1_idx_p0 == RR_W'(r))) begin
          rspVect_o[r*DEPTH +: DEPTH] <= port1_vect_p0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ldq_cam_ctrl.sv
// Self-checking bench for ldq_cam_ctrl (DEPTH=16, WIDTH=8, NUM_REQ=3).
// A behavioural CAM answers the search ports; a reference model tracks the
// intended CAM contents, arbitration pointer and expected responses.
module tb_ldq_cam_ctrl;
  localparam int DEPTH   = 16;
  localparam int INDEX   = 4;
  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready_o;
  logic [2:0]  reqValid_i;
  logic [23:0] reqTag_i;
  logic [2:0]  reqReady_o;
  logic [2:0]  rspValid_o;
  logic [47:0] rspVect_o;
  logic [15:0] entryValid_i;
  logic [1:0]  wrValid_i;
  logic [7:0]  wrAddr_i;
  logic [15:0] wrData_i;
  logic        wrReady_o;
  logic [7:0]  camTag0_o, camTag1_o;
  logic [15:0] camVect0_i, camVect1_i;
  logic        camWe0_o, camWe1_o;
  logic [3:0]  camWrAddr0_o, camWrAddr1_o;
  logic [7:0]  camWrData0_o, camWrData1_o;

  always #5 clk = ~clk;

  ldq_cam_ctrl #(.DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .reset(reset), .ready_o(ready_o),
    .reqValid_i(reqValid_i), .reqTag_i(reqTag_i), .reqReady_o(reqReady_o),
    .rspValid_o(rspValid_o), .rspVect_o(rspVect_o), .entryValid_i(entryValid_i),
    .wrValid_i(wrValid_i), .wrAddr_i(wrAddr_i), .wrData_i(wrData_i), .wrReady_o(wrReady_o),
    .camTag0_o(camTag0_o), .camTag1_o(camTag1_o),
    .camVect0_i(camVect0_i), .camVect1_i(camVect1_i),
    .camWe0_o(camWe0_o), .camWe1_o(camWe1_o),
    .camWrAddr0_o(camWrAddr0_o), .camWrAddr1_o(camWrAddr1_o),
    .camWrData0_o(camWrData0_o), .camWrData1_o(camWrData1_o)
  );

  // Behavioural CAM driven by the controller's write/search ports.
  logic [7:0] cam_mem [16];
  always @(posedge clk) begin
    if (camWe0_o) cam_mem[camWrAddr0_o] <= camWrData0_o;
    if (camWe1_o) cam_mem[camWrAddr1_o] <= camWrData1_o;
  end
  always_comb begin
    camVect0_i = '0;
    camVect1_i = '0;
    for (int i = 0; i < 16; i++) begin
      camVect0_i[i] = (cam_mem[i] == camTag0_o);
      camVect1_i[i] = (cam_mem[i] == camTag1_o);
    end
  end

  // Reference model state.
  logic [7:0]  mem_ref [16];
  int          rr_ref;
  logic [47:0] exp_vect;
  logic [2:0]  e_grant, e_rspv;
  logic        e_we0, e_we1;
  logic [7:0]  e_tag0, e_tag1;
  logic [2:0]  c_grant;
  logic        c_we0, c_we1, c_wrready;
  logic [7:0]  c_tag0, c_tag1;

  int n_tests, n_fail;

  function automatic logic [15:0] ref_match(input logic [7:0] t, input logic [15:0] ev);
    logic [15:0] m;
    for (int i = 0; i < 16; i++) m[i] = (mem_ref[i] == t) && ev[i];
    return m;
  endfunction

  function automatic logic [7:0] pick_val();
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return 8'h11;
      2:       return 8'h22;
      default: return 8'h33;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mem_ref[i] = 8'h00;
    rr_ref   = 0;
    exp_vect = '0;
  endtask

  // Drive one RUN cycle, capture combinational outputs, advance the model,
  // and return #1 after the clock edge.
  task automatic apply(input logic [2:0] v, input logic [23:0] tags, input logic [15:0] ev,
                       input logic [1:0] wv, input logic [7:0] a, input logic [15:0] d);
    int first, second, last;
    logic [15:0] m;
    @(negedge clk);
    reqValid_i = v; reqTag_i = tags; entryValid_i = ev;
    wrValid_i = wv; wrAddr_i = a; wrData_i = d;
    #1;
    c_grant = reqReady_o; c_we0 = camWe0_o; c_we1 = camWe1_o;
    c_tag0 = camTag0_o; c_tag1 = camTag1_o; c_wrready = wrReady_o;
    first = -1; second = -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      int r;
      r = (rr_ref + i) % NUM_REQ;
      if (v[r]) begin
        if (first < 0) first = r;
        else if (second < 0) second = r;
      end
    end
    e_grant = '0;
    if (first >= 0) e_grant[first] = 1'b1;
    if (second >= 0) e_grant[second] = 1'b1;
    e_tag0 = (first >= 0) ? tags[first*8 +: 8] : 8'h00;
    e_tag1 = (second >= 0) ? tags[second*8 +: 8] : 8'h00;
    e_we1 = wv[1];
    e_we0 = wv[0] && !(wv[1] && (a[3:0] == a[7:4]));
    e_rspv = e_grant;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (e_grant[r]) begin
        m = ref_match(tags[r*8 +: 8], ev);
`ifdef LDQ_WR_BYPASS_EN
        for (int k = 0; k < 2; k++)
          if (wv[k]) m[a[k*4 +: 4]] = (d[k*8 +: 8] == tags[r*8 +: 8]) && ev[a[k*4 +: 4]];
`endif
        exp_vect[r*16 +: 16] = m;
      end
    end
    last = (second >= 0) ? second : first;
    if (first >= 0) rr_ref = (last + 1) % NUM_REQ;
    if (wv[0]) mem_ref[a[3:0]] = d[7:0];
    if (wv[1]) mem_ref[a[7:4]] = d[15:8];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic zero;
    #12;
    n_tests++;
    if ({ready_o, rspValid_o} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {ready_o, rspValid_o});
    end
    n_tests++;
    if (rspVect_o !== 48'h0) begin
      n_fail++; $display("FAIL reset_vect: got %h want 0", rspVect_o);
    end
    // Requests and writes held high during the sweep must be ignored.
    reqValid_i = 3'b111; reqTag_i = '1; wrValid_i = 2'b11; wrAddr_i = 8'h33; wrData_i = 16'hFFFF;
    entryValid_i = 16'hFFFF;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_tests++;
      if ({camWe1_o, camWe0_o, camWrAddr1_o, camWrAddr0_o, camWrData1_o, camWrData0_o} !==
          {2'b11, 4'(2*c+1), 4'(2*c), 16'h0}) begin
        n_fail++;
        $display("FAIL init_write[%0d]: got we=%b%b a=%0d/%0d d=%h/%h want we=11 a=%0d/%0d d=0",
                 c, camWe1_o, camWe0_o, camWrAddr1_o, camWrAddr0_o, camWrData1_o, camWrData0_o,
                 2*c+1, 2*c);
      end
      n_tests++;
      if ({ready_o, wrReady_o, reqReady_o, rspValid_o} !== 8'h0) begin
        n_fail++; $display("FAIL init_gate[%0d]: got %b want 0", c,
                           {ready_o, wrReady_o, reqReady_o, rspValid_o});
      end
      @(negedge clk);
    end
    #1;
    n_tests++;
    if ({ready_o, reqReady_o, camWe1_o, camWe0_o} !== 6'b0) begin
      n_fail++; $display("FAIL ready_early: got %b want 0", {ready_o, reqReady_o, camWe1_o, camWe0_o});
    end
    reqValid_i = '0; wrValid_i = '0; reqTag_i = '0;
    @(posedge clk);
    #1;
    n_tests++;
    if (ready_o !== 1'b1) begin
      n_fail++; $display("FAIL ready_rise: got %b want 1", ready_o);
    end
    zero = 1'b1;
    for (int i = 0; i < 16; i++) if (cam_mem[i] !== 8'h00) zero = 1'b0;
    n_tests++;
    if (zero !== 1'b1) begin
      n_fail++; $display("FAIL init_zero: got %b want 1", zero);
    end
    model_clear();
  endtask

  task automatic test_round_robin();
    logic [2:0] want;
    logic [2:0] prev;
    prev = 3'b000;
    for (int k = 0; k < 3; k++) begin
      want = (k == 0) ? 3'b011 : (k == 1) ? 3'b101 : 3'b110;
      apply(3'b111, 24'h0, 16'h0, 2'b00, 8'h0, 16'h0);
      n_tests++;
      if (c_grant !== want || c_grant !== e_grant) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", k, c_grant, want);
      end
      n_tests++;
      if (rspValid_o !== want) begin
        n_fail++; $display("FAIL rr_rspvalid[%0d]: got %b want %b", k, rspValid_o, want);
      end
      prev = want;
    end
    apply(3'b000, 24'h0, 16'h0, 2'b00, 8'h0, 16'h0);
    n_tests++;
    if (rspValid_o !== 3'b000 || c_grant !== 3'b000) begin
      n_fail++; $display("FAIL rr_idle: got rsp=%b gnt=%b want 000 (prev %b)", rspValid_o, c_grant, prev);
    end
  endtask

  task automatic test_write_search();
    apply(3'b000, 24'h0, 16'hFFFF, 2'b01, {4'd0, 4'd3}, {8'h00, 8'h5A});
    n_tests++;
    if ({c_wrready, c_we1, c_we0} !== 3'b101) begin
      n_fail++; $display("FAIL ws_write: got %b want 101", {c_wrready, c_we1, c_we0});
    end
    apply(3'b001, {8'h00, 8'h00, 8'h5A}, 16'hFFFF, 2'b00, 8'h0, 16'h0);
    n_tests++;
    if (c_tag0 !== 8'h5A) begin
      n_fail++; $display("FAIL ws_tag: got %h want 5a", c_tag0);
    end
    n_tests++;
    if (rspValid_o !== 3'b001 || rspVect_o[15:0] !== 16'h0008 || rspVect_o !== exp_vect) begin
      n_fail++; $display("FAIL ws_rsp: got v=%b %h want v=001 0008", rspValid_o, rspVect_o[15:0]);
    end
  endtask

  task automatic test_same_addr();
    apply(3'b000, 24'h0, 16'hFFFF, 2'b11, {4'd5, 4'd5}, {8'h22, 8'h11});
    n_tests++;
    if ({c_we1, c_we0} !== 2'b10) begin
      n_fail++; $display("FAIL same_we: got %b want 10", {c_we1, c_we0});
    end
    n_tests++;
    if (cam_mem[5] !== 8'h22) begin
      n_fail++; $display("FAIL same_mem: got %h want 22", cam_mem[5]);
    end
    // rr points at requester 1: req1 (0x22) takes port 0, req0 (0x11) port 1.
    apply(3'b011, {8'h00, 8'h22, 8'h11}, 16'hFFFF, 2'b00, 8'h0, 16'h0);
    n_tests++;
    if ({c_tag0, c_tag1} !== 16'h2211) begin
      n_fail++; $display("FAIL same_tags: got %h want 2211", {c_tag0, c_tag1});
    end
    n_tests++;
    if (rspVect_o[31:0] !== 32'h0020_0000 || rspValid_o !== 3'b011) begin
      n_fail++; $display("FAIL same_rsp: got v=%b %h want v=011 00200000", rspValid_o, rspVect_o[31:0]);
    end
  endtask

  task automatic test_bypass();
    logic [15:0] want;
`ifdef LDQ_WR_BYPASS_EN
    want = 16'h0080;
`else
    want = 16'h0000;
`endif
    apply(3'b001, {8'h00, 8'h00, 8'h33}, 16'hFFFF, 2'b01, {4'd0, 4'd7}, {8'h00, 8'h33});
    n_tests++;
    if (rspVect_o[15:0] !== want || rspValid_o !== 3'b001) begin
      n_fail++; $display("FAIL bypass_same: got v=%b %h want v=001 %h", rspValid_o, rspVect_o[15:0], want);
    end
    apply(3'b001, {8'h00, 8'h00, 8'h33}, 16'hFFFF, 2'b00, 8'h0, 16'h0);
    n_tests++;
    if (rspVect_o[15:0] !== 16'h0080) begin
      n_fail++; $display("FAIL bypass_after: got %h want 0080", rspVect_o[15:0]);
    end
  endtask

  task automatic test_random();
    logic [2:0]  v;
    logic [23:0] tags;
    logic [15:0] ev, d;
    logic [1:0]  wv;
    logic [7:0]  a;
    logic        same;
    for (int n = 0; n < 400; n++) begin
      v = 3'($urandom);
      tags = {pick_val(), pick_val(), pick_val()};
      ev = 16'($urandom) | 16'h0F0F;
      wv = 2'($urandom);
      a[3:0] = 4'($urandom);
      a[7:4] = ($urandom_range(0, 3) == 0) ? a[3:0] : 4'($urandom);
      d = {pick_val(), pick_val()};
      apply(v, tags, ev, wv, a, d);
      n_tests++;
      if (c_grant !== e_grant) begin
        n_fail++; $display("FAIL rnd_grant[%0d]: got %b want %b", n, c_grant, e_grant);
      end
      n_tests++;
      if ({c_we1, c_we0} !== {e_we1, e_we0}) begin
        n_fail++; $display("FAIL rnd_we[%0d]: got %b want %b", n, {c_we1, c_we0}, {e_we1, e_we0});
      end
      n_tests++;
      if ({c_tag1, c_tag0} !== {e_tag1, e_tag0}) begin
        n_fail++; $display("FAIL rnd_tag[%0d]: got %h want %h", n, {c_tag1, c_tag0}, {e_tag1, e_tag0});
      end
      n_tests++;
      if (rspValid_o !== e_rspv) begin
        n_fail++; $display("FAIL rnd_rspvalid[%0d]: got %b want %b", n, rspValid_o, e_rspv);
      end
      n_tests++;
      if (rspVect_o !== exp_vect) begin
        n_fail++; $display("FAIL rnd_rspvect[%0d]: got %h want %h", n, rspVect_o, exp_vect);
      end
    end
    same = 1'b1;
    for (int i = 0; i < 16; i++) if (cam_mem[i] !== mem_ref[i]) same = 1'b0;
    n_tests++;
    if (same !== 1'b1) begin
      n_fail++; $display("FAIL rnd_contents: got %b want 1", same);
    end
  endtask

  task automatic test_reset_midrun();
    logic zero;
    apply(3'b111, {8'h11, 8'h22, 8'h33}, 16'hFFFF, 2'b11, {4'd9, 4'd2}, {8'h11, 8'h22});
    n_tests++;
    if (rspValid_o !== e_rspv) begin
      n_fail++; $display("FAIL mid_inflight: got %b want %b", rspValid_o, e_rspv);
    end
    #1 reset = 1'b0;
    #1;
    n_tests++;
    if ({ready_o, wrReady_o, reqReady_o, rspValid_o} !== 8'h0 || rspVect_o !== 48'h0) begin
      n_fail++; $display("FAIL mid_clear: got %b %h want 0 0",
                         {ready_o, wrReady_o, reqReady_o, rspValid_o}, rspVect_o);
    end
    n_tests++;
    if ({camWe1_o, camWe0_o, camWrAddr1_o, camWrAddr0_o} !== {2'b11, 4'd1, 4'd0}) begin
      n_fail++; $display("FAIL mid_init: got %b want 1100010000",
                         {camWe1_o, camWe0_o, camWrAddr1_o, camWrAddr0_o});
    end
    @(negedge clk);
    @(negedge clk);
    reqValid_i = '0; wrValid_i = '0;
    reset = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    n_tests++;
    if (ready_o !== 1'b1) begin
      n_fail++; $display("FAIL mid_ready: got %b want 1", ready_o);
    end
    zero = 1'b1;
    for (int i = 0; i < 16; i++) if (cam_mem[i] !== 8'h00) zero = 1'b0;
    n_tests++;
    if (zero !== 1'b1) begin
      n_fail++; $display("FAIL mid_zero: got %b want 1", zero);
    end
    model_clear();
    apply(3'b111, 24'h0, 16'h0, 2'b00, 8'h0, 16'h0);
    n_tests++;
    if (c_grant !== 3'b011) begin
      n_fail++; $display("FAIL mid_rr: got %b want 011", c_grant);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b0;
    reqValid_i = '0; reqTag_i = '0; entryValid_i = '0;
    wrValid_i = '0; wrAddr_i = '0; wrData_i = '0;
    model_clear();
    test_reset();
    test_round_robin();
    test_write_search();
    test_same_addr();
    test_bypass();
    test_random();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
